// File: rtl/ntt_stage_sequencer_if.sv
// Purpose: bundles the request, read, butterfly-control and write-back signals of ntt_stage_sequencer.
// Ports:   master = requester (drives start/op/swap_in/w_base), slave = sequencer (drives everything else).
// Widths:  row addresses are clog2(2*PAIRS) bits, twiddle indices are clog2(LUT_SIZE) bits.
interface ntt_stage_sequencer_if #(
  parameter int PAIRS    = 8,
  parameter int LUT_SIZE = 1360
);
  localparam int AW = $clog2(2 * PAIRS);
  localparam int WW = $clog2(LUT_SIZE);

  // request side
  logic          start;
  logic          op;
  logic          swap_in;
  logic [WW-1:0] w_base;

  // read issue
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;

  // butterfly array controls, aligned to read data arrival
  logic          bf_mode;
  logic          bf_swap;
  logic [WW-1:0] w_idx;

  // write-back, aligned to array outputs
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr_a;
  logic [AW-1:0] wr_addr_b;

  // status
  logic          busy;
  logic          done;
  logic          res_bank;

  modport master (
    output start, op, swap_in, w_base,
    input  rd_en, rd_bank, rd_addr_a, rd_addr_b,
    input  bf_mode, bf_swap, w_idx,
    input  wr_en, wr_bank, wr_addr_a, wr_addr_b,
    input  busy, done, res_bank
  );

  modport slave (
    input  start, op, swap_in, w_base,
    output rd_en, rd_bank, rd_addr_a, rd_addr_b,
    output bf_mode, bf_swap, w_idx,
    output wr_en, wr_bank, wr_addr_a, wr_addr_b,
    output busy, done, res_bank
  );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Purpose: sequences one NTT pass (NUM_LAYERS layers) or one pointwise-multiply pass over ping-pong row banks.
// Latency: one row pair per cycle; controls RD_LATENCY after the read, writes RD_LATENCY+BF_LATENCY after the read.
// Backpressure: none; start is only sampled in IDLE; each layer costs PAIRS+RD_LATENCY+BF_LATENCY cycles.
// Ports: clk, reset (async, active-low), bus (slave modport of ntt_stage_sequencer_if).
module ntt_stage_sequencer #(
  parameter int PAIRS      = 8,
  parameter int NUM_LAYERS = 4,
  parameter int LUT_SIZE   = 1360,
  parameter int RD_LATENCY = 1,
  parameter int BF_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  ntt_stage_sequencer_if.slave  bus
);
  localparam int AW     = $clog2(2 * PAIRS);
  localparam int WW     = $clog2(LUT_SIZE);
  localparam int LW     = $clog2(NUM_LAYERS + 1);
  localparam int WR_LAT = RD_LATENCY + BF_LATENCY;
  localparam int DW     = $clog2(WR_LAT + 1);
  // The result of an NTT ends up in the bank written by the last layer.
  localparam logic NL0  = 1'(NUM_LAYERS % 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic          mode;
    logic          swap;
    logic [WW-1:0] w;
  } bf_t;

  typedef struct packed {
    logic          en;
    logic          bank;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wr_t;

  logic [1:0]    state_q;
  logic [AW-1:0] p_q;
  logic [LW-1:0] layer_q;
  logic [DW-1:0] dcnt_q;
  logic          op_q;
  logic          swap_q;
  logic [WW-1:0] wbase_q;
  logic          res_q;

  logic          iss;
  logic          rd_bank;
  logic [AW-1:0] rd_a;
  logic [AW-1:0] rd_b;
  bf_t           bf_iss;
  wr_t           wr_iss;

  bf_t           bf_pipe [RD_LATENCY];
  wr_t           wr_pipe [WR_LAT];

  // Issue-cycle values; everything is forced to zero outside ISSUE so the
  // delay lines carry zeros (and hence quiet outputs) between reads.
  always_comb begin
    iss     = (state_q == ISSUE);
    rd_bank = 1'b0;
    rd_a    = '0;
    rd_b    = '0;
    bf_iss  = '0;
    wr_iss  = '0;
    if (iss) begin
      rd_a      = p_q;
      rd_b      = AW'(32'(p_q) + PAIRS);
      wr_iss.en = 1'b1;
      if (op_q) begin
        // pointwise multiply works in place on bank 0
        wr_iss.a    = rd_a;
        wr_iss.b    = rd_b;
        bf_iss.mode = 1'b1;
        bf_iss.swap = swap_q;
        bf_iss.w    = WW'(32'(wbase_q) + 32'(p_q));
      end else begin
        // constant-geometry layer: read halves, write interleaved into the other bank
        rd_bank     = layer_q[0];
        wr_iss.bank = ~layer_q[0];
        wr_iss.a    = AW'(32'(p_q) * 2);
        wr_iss.b    = AW'(32'(p_q) * 2 + 1);
        bf_iss.w    = WW'(32'(wbase_q) + 32'(layer_q) * PAIRS + 32'(p_q));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      layer_q <= '0;
      dcnt_q  <= '0;
      op_q    <= 1'b0;
      swap_q  <= 1'b0;
      wbase_q <= '0;
      res_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= ISSUE;
            op_q    <= bus.op;
            swap_q  <= bus.swap_in;
            wbase_q <= bus.w_base;
            res_q   <= bus.op ? 1'b0 : NL0;
            p_q     <= '0;
            layer_q <= '0;
          end
        end
        ISSUE: begin
          if (32'(p_q) == PAIRS - 1) begin
            state_q <= DRAIN;
            p_q     <= '0;
            dcnt_q  <= '0;
          end else begin
            p_q <= p_q + 1'b1;
          end
        end
        DRAIN: begin
          // the last write of the layer leaves the pipe in the final DRAIN cycle
          if (32'(dcnt_q) == WR_LAT - 1) begin
            if (op_q || (32'(layer_q) == NUM_LAYERS - 1)) begin
              state_q <= DONE;
            end else begin
              layer_q <= layer_q + 1'b1;
              state_q <= ISSUE;
            end
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Delay lines shift unconditionally; reset discards anything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LATENCY; i++) bf_pipe[i] <= '0;
      for (int i = 0; i < WR_LAT; i++)     wr_pipe[i] <= '0;
    end else begin
      bf_pipe[0] <= bf_iss;
      for (int i = 1; i < RD_LATENCY; i++) bf_pipe[i] <= bf_pipe[i-1];
      wr_pipe[0] <= wr_iss;
      for (int i = 1; i < WR_LAT; i++)     wr_pipe[i] <= wr_pipe[i-1];
    end
  end

  assign bus.rd_en     = iss;
  assign bus.rd_bank   = rd_bank;
  assign bus.rd_addr_a = rd_a;
  assign bus.rd_addr_b = rd_b;
  assign bus.bf_mode   = bf_pipe[RD_LATENCY-1].mode;
  assign bus.bf_swap   = bf_pipe[RD_LATENCY-1].swap;
  assign bus.w_idx     = bf_pipe[RD_LATENCY-1].w;
  assign bus.wr_en     = wr_pipe[WR_LAT-1].en;
  assign bus.wr_bank   = wr_pipe[WR_LAT-1].bank;
  assign bus.wr_addr_a = wr_pipe[WR_LAT-1].a;
  assign bus.wr_addr_b = wr_pipe[WR_LAT-1].b;
  assign bus.busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.res_bank  = res_q;
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Purpose: scoreboard bench for ntt_stage_sequencer with default parameters (PAIRS=8, 4 layers, 11-bit w_idx).
// Stimulus pushes expected reads/controls/writes/done per pass; a negedge monitor pops and compares.
// Also checks read-to-write spacing, layer non-overlap, reset behaviour and ignored start pulses.
module tb_ntt_stage_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ntt_stage_sequencer_if #(.PAIRS(8), .LUT_SIZE(1360)) bus ();

  ntt_stage_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int start_cyc = 0;
  int wr_cnt  = 0;
  int done_cnt = 0;
  logic prev_rd = 1'b0;

  logic [63:0] rd_q[$];
  logic [63:0] bf_q[$];
  logic [63:0] wr_q[$];
  logic [63:0] done_q[$];
  int          rdc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.rd_en, bus.rd_bank, bus.rd_addr_a, bus.rd_addr_b,
                bus.bf_mode, bus.bf_swap, bus.w_idx,
                bus.wr_en, bus.wr_bank, bus.wr_addr_a, bus.wr_addr_b,
                bus.busy, bus.done, bus.res_bank});
  endfunction

  // Expected traffic for one pass. Each layer takes 8 issue + 1 read + 3 butterfly
  // cycles, so done lands 12*layers+1 cycles after the start cycle.
  // res_bank is 0 for both ops here because NUM_LAYERS=4 is even.
  task automatic push_pass(input bit o, input bit sw, input int wb);
    int nl;
    logic [3:0]  a, b, wa, wb_;
    logic [10:0] w;
    logic        rbank, wbank;
    nl = o ? 1 : 4;
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < 8; p++) begin
        a = 4'(p);
        b = 4'(p + 8);
        if (o) begin
          rbank = 1'b0; wbank = 1'b0; wa = a; wb_ = b;
          w = 11'((wb + p) % 2048);
          bf_q.push_back(64'({1'b1, sw, w}));
        end else begin
          rbank = 1'(l % 2); wbank = ~rbank;
          wa = 4'(2 * p); wb_ = 4'(2 * p + 1);
          w = 11'((wb + l * 8 + p) % 2048);
          bf_q.push_back(64'({1'b0, 1'b0, w}));
        end
        rd_q.push_back(64'({rbank, a, b}));
        wr_q.push_back(64'({wbank, wa, wb_}));
      end
    end
    done_q.push_back(64'({1'b0, 32'(12 * nl + 1)}));
  endtask

  task automatic pulse(input bit o, input bit sw, input int wb);
    @(posedge clk); #1;
    bus.op = o; bus.swap_in = sw; bus.w_base = 11'(wb);
    bus.start = 1'b1;
    start_cyc = cyc;
    push_pass(o, sw, wb);
    @(posedge clk); #1;
    bus.start = 1'b0;
    // change request inputs after acceptance; they must have no effect
    bus.op = ~o; bus.swap_in = ~sw; bus.w_base = 11'(wb + 333);
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_pass();
    for (int i = 0; i < 300 && (done_q.size() != 0 || wr_q.size() != 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("pass_complete", 64'(done_q.size() + wr_q.size() + rd_q.size() + bf_q.size()), 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (!reset) begin
      prev_rd = 1'b0;
    end else begin
      if (prev_rd) begin
        if (bf_q.size() == 0) chk("bf_unexpected", 1, 0);
        else chk("bf_ctrl", 64'({bus.bf_mode, bus.bf_swap, bus.w_idx}), bf_q.pop_front());
      end
      if (bus.rd_en) begin
        // first read of a layer: the previous layer's writes must all be out
        if (bus.rd_addr_a == 4'd0) chk("rd_overlap", 64'(rdc_q.size()), 0);
        rdc_q.push_back(cyc);
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd", 64'({bus.rd_bank, bus.rd_addr_a, bus.rd_addr_b}), rd_q.pop_front());
      end
      if (bus.wr_en) begin
        wr_cnt++;
        if (rdc_q.size() == 0) chk("wr_latency", 1, 0);
        else chk("wr_latency", 64'(cyc - rdc_q.pop_front()), 4);
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr", 64'({bus.wr_bank, bus.wr_addr_a, bus.wr_addr_b}), wr_q.pop_front());
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_busy", bus.busy, 0);
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done", 64'({bus.res_bank, 32'(cyc - start_cyc)}), done_q.pop_front());
      end
      prev_rd = bus.rd_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, d0;
    bus.start = 1'b0; bus.op = 1'b0; bus.swap_in = 1'b0; bus.w_base = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", outs(), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_outputs", outs(), 0);

    // NTT, w_base 0: 4 layers, 32 writes
    w0 = wr_cnt;
    pulse(1'b0, 1'b0, 0);
    wait_pass();
    chk("ntt_wr_count", 64'(wr_cnt - w0), 32);

    // Multiply with swap, w_base 100
    w0 = wr_cnt;
    pulse(1'b1, 1'b1, 100);
    wait_pass();
    chk("mul_wr_count", 64'(wr_cnt - w0), 8);

    // Multiply from w_base 1358 (indices run past LUT_SIZE)
    pulse(1'b1, 1'b0, 1358);
    wait_pass();

    // NTT from w_base 2040: indices wrap modulo 2048
    pulse(1'b0, 1'b0, 2040);
    wait_pass();

    // start held high for the whole pass, inputs changed mid-pass
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.op = 1'b0; bus.swap_in = 1'b0; bus.w_base = 11'd5;
    bus.start = 1'b1;
    start_cyc = cyc;
    push_pass(1'b0, 1'b0, 5);
    @(posedge clk); #1;
    bus.op = 1'b1; bus.swap_in = 1'b1; bus.w_base = 11'd900;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    bus.start = 1'b0;
    wait_pass();
    repeat (10) @(posedge clk); #1;
    chk("single_done", 64'(done_cnt - d0), 1);

    // reset in the DRAIN of layer 2 (0-based)
    pulse(1'b0, 1'b0, 0);
    repeat (33) @(posedge clk); #1;
    chk("busy_before_abort", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_outputs", outs(), 0);
    rd_q.delete(); bf_q.delete(); wr_q.delete(); done_q.delete(); rdc_q.delete();
    w0 = wr_cnt;
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) @(posedge clk); #1;
    chk("no_wr_after_abort", 64'(wr_cnt - w0), 0);
    chk("idle_after_abort", outs(), 0);

    // clean pass after the abort
    pulse(1'b0, 1'b0, 7);
    wait_pass();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ntt_stage_sequencer.md
Name: ntt_stage_sequencer

Overview:
Control stage directly upstream of the butterfly array. It sequences one NTT pass (NUM_LAYERS constant-geometry layers) or one pointwise-multiply pass over a ping-pong pair of vector-row memories. Per row pair it issues memory reads and drives mode, swap and w_idx aligned to data arrival at the array. It generates matching write-back strobes and addresses, delayed by the array's pipeline latency.

Parameters:
PAIRS, 8, row pairs per layer; each memory bank holds 2*PAIRS rows of SIZE coefficients
NUM_LAYERS, 4, butterfly layers per NTT pass (>=1)
LUT_SIZE, 1360, twiddle table depth; sets w_idx width
RD_LATENCY, 1, cycles from rd_en to read data valid at array inputs (>=1)
BF_LATENCY, 3, cycles from array inputs to A_out/B_out valid (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
op  in  1  0 = NTT pass, 1 = pointwise multiply pass
swap_in  in  1  multiply A instead of B; latched at start
w_base  in  clog2(LUT_SIZE)  twiddle base index; latched at start
rd_en  out  1  read strobe for both rows
rd_bank  out  1  bank to read
rd_addr_a  out  clog2(2*PAIRS)  row feeding A
rd_addr_b  out  clog2(2*PAIRS)  row feeding B
bf_mode  out  1  array mode, aligned to array inputs
bf_swap  out  1  array swap, aligned to array inputs
w_idx  out  clog2(LUT_SIZE)  twiddle index, aligned to array inputs
wr_en  out  1  write strobe for A_out/B_out
wr_bank  out  1  bank to write
wr_addr_a  out  clog2(2*PAIRS)  destination of A_out
wr_addr_b  out  clog2(2*PAIRS)  destination of B_out
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle completion pulse
res_bank  out  1  bank holding the final result; valid from done

Behaviour:
- Reset (reset low, async): state IDLE, all outputs 0, counters 0, delay lines cleared.
- FSM: IDLE -> ISSUE on start; ISSUE -> DRAIN after p = PAIRS-1 issued; DRAIN -> ISSUE (next layer) or DONE once the write pipe is empty; DONE -> IDLE after 1 cycle (done=1, busy=0 there).
- ISSUE: one pair per cycle, rd_en=1, p counts 0..PAIRS-1.
- NTT, layer l: rd_bank = l[0], rd_addr_a = p, rd_addr_b = p+PAIRS; write bank = ~l[0], wr_addr_a = 2p, wr_addr_b = 2p+1; mode 0, swap 0; w_idx = w_base + l*PAIRS + p, truncated to clog2(LUT_SIZE) bits (wraps modulo 2^width, no saturation).
- Multiply: a single layer, rd_bank = wr_bank = 0, addresses p / p+PAIRS both ways (in place); mode 1, swap = latched swap_in; w_idx = w_base + p.
- Alignment: bf_mode, bf_swap and w_idx equal issue-cycle values delayed RD_LATENCY cycles. wr_en, wr_bank and wr_addr_* equal issue values delayed RD_LATENCY+BF_LATENCY cycles. Delay lines are shift registers that keep shifting in every state.
- DRAIN: waits until the last write of the layer has asserted wr_en, with no read overlap. Each layer costs PAIRS + RD_LATENCY + BF_LATENCY cycles.
- res_bank: NUM_LAYERS[0] for NTT, 0 for multiply. Holds until the next accepted start.
- start while busy or in DONE is ignored, with no latching. op, swap_in and w_base are ignored after acceptance.
- Reset asserted mid-pass aborts immediately. Pending delayed writes are discarded (no wr_en after reset release).

Test Plan:
- NTT defaults, w_base=0, start -> 4 layers x 8 reads; layer 1 reads bank 1 and writes bank 0; layer 1 p=3: w_idx=11, rd_addr 3/11, wr_addr 6/7; done at cycle 4*(8+1+3)+1 after start; res_bank=0.
- Alignment: w_idx changes exactly 1 cycle after rd_en; wr_en exactly 4 cycles after rd_en; wr_en count = 32; no rd_en while wr_en for the same layer is pending.
- Multiply, swap_in=1, w_base=100 -> 8 reads; bf_mode=1, bf_swap=1; w_idx 100..107; wr_addr = rd_addr, bank 0; done; res_bank=0.
- Wrap: w_base=1358, multiply -> w_idx 1358, 1359, 1360, 1361, ... modulo 2048, no stall.
- start pulsed every cycle during a pass -> exactly one done, and the pass is not restarted.
- reset low during layer 2 DRAIN -> all outputs 0 at once; no wr_en after release; a new start runs a clean pass.
